fetch_sequencer: RTL and testbench

Program-counter and fetch controller for the 9-bit lab CPU. It drives the 8-bit address of the combinational instruction ROM and registers the returned word into a fetch register with a valid flag. It also handles start, stall, branch redirect and halt for the decode/execute stages downstream. It sits between the instruction ROM and the decoder and is the only block that sequences the ROM address.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_sequencer_pc_reg.sv | 26 ++
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and state type for the lab CPU fetch path.
// Imported by the fetch sequencer and its PC register.
package cpu_pkg;

    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 9;
    localparam int RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter with load, increment and hold.
// Increment wraps modulo 2**ADDR_W with no carry out.
module pc_reg #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] pc
);

    // PC update: load wins over increment, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC and fetch controller: IDLE/RUN/HALT sequencing of the ROM.
// Define FETCH_INSTR_COUNT_EN to build the retired-instruction counter.
module fetch_sequencer #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int INSTR_W  = cpu_pkg::INSTR_W,
    parameter int RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               running,
    output logic               done,
    output logic [15:0]        instr_count
);

    import cpu_pkg::*;

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_value;
    logic              fetch;
    logic              flush;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .inc        (pc_inc),
        .load_value (pc_value),
        .pc         (address)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and PC/fetch controls; halt > branch > stall > advance.
    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_value   = ADDR_W'(RESET_PC);
        fetch      = 1'b0;
        flush      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    pc_load    = 1'b1;
                end
            end
            RUN: begin
                if (halt && instr_valid) begin
                    next_state = HALT;
                    flush      = 1'b1;
                end else if (branch_taken && instr_valid) begin
                    pc_load  = 1'b1;
                    pc_value = branch_target;
                    flush    = 1'b1;
                end else if (!stall) begin
                    fetch  = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            HALT: begin
                if (start) begin
                    next_state = RUN;
                    pc_load    = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Fetch register; a flush drops the wrong-path or halting word.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (fetch) begin
            instr_out   <= instruction;
            instr_pc    <= address;
            instr_valid <= 1'b1;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == HALT);

`ifdef FETCH_INSTR_COUNT_EN
    logic        consume;
    logic        clear_count;
    logic [15:0] count_q;

    assign consume     = (state == RUN) && instr_valid && !stall;
    assign clear_count = start && (state != RUN);

    // Saturating count of consumed instructions, cleared on start.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_count) begin
            count_q <= '0;
        end else if (consume && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed plan then random run.
// Reference model applies the sequencing rules per cycle.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [7:0]  addr;
        logic [8:0]  out;
        logic [7:0]  ipc;
        logic        valid;
        logic        running;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'd0;
    logic        halt = 1'b0;
    logic [7:0]  address;
    logic [8:0]  instruction;
    logic [8:0]  instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        running;
    logic        done;
    logic [15:0] instr_count;

    logic [8:0] rom [256];
    exp_t       q[$];
    int         asserts = 0;
    int         fails = 0;

    // Model state: mode 0 = idle, 1 = running, 2 = halted.
    int         m_mode = 0;
    int         m_pc = 0;
    int         m_out = 0;
    int         m_ipc = 0;
    int         m_valid = 0;
    int         m_cnt = 0;

    assign instruction = rom[address];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .address       (address),
        .instruction   (instruction),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .running       (running),
        .done          (done),
        .instr_count   (instr_count)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h want %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model(input bit rs, input bit st, input bit sl,
                         input bit br, input int tg, input bit hl);
        bit used;
        if (rs) begin
            m_mode = 0; m_pc = 0; m_out = 0;
            m_ipc = 0; m_valid = 0; m_cnt = 0;
            return;
        end
        if (m_mode == 1) begin
            used = (m_valid == 1) && !sl;
`ifdef FETCH_INSTR_COUNT_EN
            if (used && m_cnt < 65535) m_cnt++;
`endif
            if (hl && m_valid == 1) begin
                m_mode = 2;
                m_valid = 0;
            end else if (br && m_valid == 1) begin
                m_pc = tg;
                m_valid = 0;
            end else if (!sl) begin
                m_out = rom[m_pc];
                m_ipc = m_pc;
                m_valid = 1;
                m_pc = (m_pc + 1) % 256;
            end
        end else if (st) begin
            m_mode = 1;
            m_pc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic step(input bit rs, input bit st, input bit sl,
                        input bit br, input int tg, input bit hl);
        exp_t e;
        @(negedge clk);
        reset = rs;
        start = st;
        stall = sl;
        branch_taken = br;
        branch_target = tg[7:0];
        halt = hl;
        model(rs, st, sl, br, tg, hl);
        e.addr    = m_pc[7:0];
        e.out     = m_out[8:0];
        e.ipc     = m_ipc[7:0];
        e.valid   = (m_valid == 1);
        e.running = (m_mode == 1);
        e.done    = (m_mode == 2);
        e.cnt     = m_cnt[15:0];
        q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every registered output after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("address", 32'(address), 32'(e.addr));
            check("instr_out", 32'(instr_out), 32'(e.out));
            check("instr_pc", 32'(instr_pc), 32'(e.ipc));
            check("instr_valid", 32'(instr_valid), 32'(e.valid));
            check("running", 32'(running), 32'(e.running));
            check("done", 32'(done), 32'(e.done));
            check("instr_count", 32'(instr_count), 32'(e.cnt));
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
        rom[0] = 9'h140;
        rom[1] = 9'h140;
        rom[2] = 9'h161;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 8'h33, 1);
        step(0, 0, 0, 1, 8'h33, 1);
        step(0, 1, 0, 0, 0, 0);
        run(2);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
        run(2);
        step(0, 0, 0, 1, 8'h40, 0);
        run(2);
        step(0, 0, 1, 1, 8'h40, 0);
        run(2);
        step(0, 0, 0, 1, 8'hFE, 0);
        run(5);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'h10, 1);
        run(2);
        step(0, 0, 0, 1, 8'h10, 1);
        step(0, 1, 0, 0, 0, 0);
        run(6);
        step(1, 0, 0, 1, 8'h20, 0);
        run(2);
        for (int i = 0; i < 3000; i++) begin
            bit rs, st, sl, br, hl;
            int tg;
            rs = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 9) == 0);
            sl = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 11) == 0);
            hl = ($urandom_range(0, 39) == 0);
            tg = ($urandom_range(0, 3) == 0) ? 8'hFE
                                             : int'($urandom_range(0, 255));
            step(rs, st, sl, br, tg, hl);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; halt = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
